// File: rtl/audio_pwm_dac.sv
// Audio PWM DAC: sample FIFO, sample-rate timer and PWM carrier driving the aud_pwm pin.
// Define AUDIO_SIGMA_DELTA_EN to replace the PWM comparator with a first-order sigma-delta.
module audio_pwm_dac #(
    parameter int unsigned CPU_CLOCK_FREQ = 100_000_000,
    parameter int unsigned SAMPLE_RATE    = 48_000,
    parameter int unsigned PWM_BITS       = 10,
    parameter int unsigned DEPTH          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [PWM_BITS-1:0]       sample_data,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      clear_underflow,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      underflow,
    output logic                      pwm_out
);

    localparam int unsigned SAMPLE_PERIOD = CPU_CLOCK_FREQ / SAMPLE_RATE;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TW-1:0]       TIMER_MAX  = TW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0]       FULL_COUNT = CW'(DEPTH);
    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;

    logic [PWM_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PWM_BITS-1:0] cur_q, cur_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                underflow_q, underflow_d;
    logic                pwm_q, pwm_d;
    logic                full, empty, push, pop, tick;

`ifdef AUDIO_SIGMA_DELTA_EN
    logic [PWM_BITS:0]   acc_q, acc_d;
`endif

    always_comb begin
        full  = (count_q == FULL_COUNT);
        empty = (count_q == '0);
        // Readiness is taken before any pop, so a full FIFO refuses even on a tick.
        push  = sample_valid && !full;
        tick  = enable && (timer_q == TIMER_MAX);
        pop   = tick && !empty;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        timer_d = (!enable || tick) ? '0 : timer_q + TW'(1);
        cur_d   = pop ? mem[rd_ptr_q] : cur_q;

        underflow_d = underflow_q;
        if (tick && empty) begin
            underflow_d = 1'b1;
        end else if (clear_underflow) begin
            underflow_d = 1'b0;
        end

        cnt_d = enable ? cnt_q + PWM_BITS'(1) : '0;
        // Tracking the sample while idle makes the first period after re-enable use it.
        duty_d = (!enable || (cnt_q == CNT_MAX)) ? cur_q : duty_q;

`ifdef AUDIO_SIGMA_DELTA_EN
        acc_d = enable ? ({1'b0, acc_q[PWM_BITS-1:0]} + {1'b0, duty_q}) : '0;
        pwm_d = acc_d[PWM_BITS];
`else
        pwm_d = enable && (cnt_q < duty_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= sample_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            cur_q       <= '0;
            duty_q      <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
            pwm_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            cur_q       <= cur_d;
            duty_q      <= duty_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
            pwm_q       <= pwm_d;
        end
    end

`ifdef AUDIO_SIGMA_DELTA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    assign sample_ready = !full;
    assign fifo_count   = count_q;
    assign underflow    = underflow_q;
    assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed bench for audio_pwm_dac: a 4096-cycle-sample instance for duty checks and a
// small fast instance (5-bit PWM, 128-cycle samples) for FIFO, underflow and reset checks.
module tb_audio_pwm_dac;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: PWM_BITS = 10, SAMPLE_PERIOD = 100_000_000 / 24_414 = 4096.
    logic       enable = 1'b0;
    logic [9:0] sample_data = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic       clear_underflow = 1'b0;
    logic [4:0] fifo_count;
    logic       underflow;
    logic       pwm_out;

    // Small instance: PWM_BITS = 5, SAMPLE_PERIOD = 128_000 / 1_000 = 128.
    logic       s_enable = 1'b0;
    logic [4:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       s_clear = 1'b0;
    logic [4:0] s_count;
    logic       s_underflow;
    logic       s_pwm;

    audio_pwm_dac #(
        .CPU_CLOCK_FREQ(100_000_000),
        .SAMPLE_RATE   (24_414),
        .PWM_BITS      (10),
        .DEPTH         (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .clear_underflow(clear_underflow),
        .fifo_count     (fifo_count),
        .underflow      (underflow),
        .pwm_out        (pwm_out)
    );

    audio_pwm_dac #(
        .CPU_CLOCK_FREQ(128_000),
        .SAMPLE_RATE   (1_000),
        .PWM_BITS      (5),
        .DEPTH         (16)
    ) dut_s (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (s_enable),
        .sample_data    (s_data),
        .sample_valid   (s_valid),
        .sample_ready   (s_ready),
        .clear_underflow(s_clear),
        .fifo_count     (s_count),
        .underflow      (s_underflow),
        .pwm_out        (s_pwm)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n = 0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    // Steps 'cycles' edges, tallying high samples and level changes of the chosen output.
    task automatic measure(input bit on_small, input int cycles, output int highs,
                           output int toggles);
        logic prev;
        logic cur;
        highs = 0;
        toggles = 0;
        prev = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            step();
            cur = on_small ? s_pwm : pwm_out;
            if (cur) highs++;
            if (k > 0 && cur != prev) toggles++;
            prev = cur;
        end
    endtask

    initial begin
        int h;
        int t;
        int hs;
        int tog512;
        int exp_tog;
        int unsigned main_vals[4];

        main_vals[0] = 256;
        main_vals[1] = 1023;
        main_vals[2] = 0;
        main_vals[3] = 512;
`ifdef AUDIO_SIGMA_DELTA_EN
        exp_tog = 1023;
`else
        exp_tog = 1;
`endif

        // Reset state
        repeat (3) step();
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ready", sample_ready, 1);
        check_eq("rst_underflow", underflow, 0);
        check_eq("rst_pwm", pwm_out, 0);
        rst_n = 1'b1;
        step();

        // Underflow on an empty FIFO; output stays low with duty 0
        s_enable = 1'b1;
        n = 0;
        hs = 0;
        measure(1, 127, h, t); hs += h;
        check_eq("uf_before_tick", s_underflow, 0);
        measure(1, 1, h, t); hs += h;
        check_eq("uf_set", s_underflow, 1);
        measure(1, 2, h, t); hs += h;
        s_clear = 1'b1;
        measure(1, 1, h, t); hs += h;
        s_clear = 1'b0;
        check_eq("uf_clear", s_underflow, 0);
        measure(1, 256 - n, h, t); hs += h;
        check_eq("uf_set_again", s_underflow, 1);
        measure(1, 383 - n, h, t); hs += h;
        s_clear = 1'b1;
        measure(1, 1, h, t); hs += h;
        s_clear = 1'b0;
        check_eq("uf_clear_vs_tick", s_underflow, 1);
        check_eq("uf_pwm_low", hs, 0);
        s_enable = 1'b0;

        // Mid-stream asynchronous reset
        s_data = 5'd31;
        s_valid = 1'b1;
        repeat (5) step();
        s_valid = 1'b0;
        s_enable = 1'b1;
        n = 0;
        run_to(200);
        check_eq("pre_rst_count", s_count, 4);
        check_eq("pre_rst_pwm", s_pwm, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_count", s_count, 0);
        check_eq("async_rst_pwm", s_pwm, 0);
        check_eq("async_rst_underflow", s_underflow, 0);
        check_eq("async_rst_ready", s_ready, 1);
        step();
        s_enable = 1'b0;
        rst_n = 1'b1;
        step();

        // Fill 17 back-to-back with playback off, then drain
        for (int v = 1; v <= 17; v++) begin
            s_data = 5'(v);
            s_valid = 1'b1;
            step();
            if (v == 16) begin
                check_eq("fill_ready_full", s_ready, 0);
                check_eq("fill_count_16", s_count, 16);
            end
        end
        s_valid = 1'b0;
        check_eq("fill_17th_dropped", s_count, 16);
        s_enable = 1'b1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            run_to(128 * (i + 1) + 32);
            measure(1, 32, h, t);
            check_eq($sformatf("drain%0d", i), h, i + 1);
        end
        check_eq("drain_empty", s_count, 0);
        check_eq("drain_no_underflow", s_underflow, 0);
        s_enable = 1'b0;

        // Duty sweep on the main instance: 256, 1023, 0, 512
        for (int i = 0; i < 4; i++) begin
            sample_data = 10'(main_vals[i]);
            sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
        check_eq("main_count_4", fifo_count, 4);
        enable = 1'b1;
        n = 0;
        tog512 = 0;
        for (int i = 0; i < 4; i++) begin
            run_to(4096 * (i + 1) + 1024);
            measure(0, 1024, h, t);
            check_eq($sformatf("duty_%0d", main_vals[i]), h, main_vals[i]);
            if (i == 3) tog512 = t;
        end
        check_eq("duty512_toggles", tog512, exp_tog);
        check_eq("main_drained", fifo_count, 0);
        check_eq("main_no_underflow", underflow, 0);
        enable = 1'b0;
        step();
        check_eq("disable_pwm_low", pwm_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
